brick_obs_ser: RTL

- Observation serializer for generated logic bricks. It is the reader/far end of the brick output pins.
- Captures a parallel word of brick outputs (e.g. the `o` pins of a nand2 array) on request.
- Shifts the word out MSB-first on a framed, strobed serial line to the test/observe controller.
- Sits beside brick arrays. Carries the standard brick supply pins so the schematic generator can place it like any other brick.

---
 rtl/brick_obs_ser.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/brick_obs_ser.sv
// Observation serializer for logic bricks: captures a parallel word and shifts it out MSB-first.
// Optional even-parity trailer bit is enabled by defining BRICK_OBS_PARITY_EN.
module brick_obs_ser #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB,
  input  logic             req,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             sdo,
  output logic             sframe,
  output logic             sstb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

`ifdef BRICK_OBS_PARITY_EN
  localparam int NB = WIDTH + 1;

  function automatic logic parity_f(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`else
  localparam int NB = WIDTH;
`endif

  localparam logic [4:0] DIV_LAST = 5'(DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(NB - 1);

  state_t          state_r, state_nxt_s;
  logic [NB-1:0]   sh_r, sh_nxt_s, cap_s, shifted_s;
  logic [4:0]      div_r, div_nxt_s;
  logic [5:0]      bit_r, bit_nxt_s;
  logic            busy_nxt_s, done_nxt_s, sdo_nxt_s, sframe_nxt_s, sstb_nxt_s;
  logic            unused_supply_s;

  // Supply pins exist only so the brick can be placed like its neighbours.
  assign unused_supply_s = ^{CELV, CELG, SUB};

`ifdef BRICK_OBS_PARITY_EN
  assign cap_s = {din, parity_f(din)};
`else
  assign cap_s = din;
`endif

  assign shifted_s = sh_r << 1;

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    state_nxt_s  = state_r;
    sh_nxt_s     = sh_r;
    div_nxt_s    = div_r;
    bit_nxt_s    = bit_r;
    busy_nxt_s   = 1'b0;
    done_nxt_s   = 1'b0;
    sdo_nxt_s    = 1'b0;
    sframe_nxt_s = 1'b0;
    sstb_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_nxt_s  = SHIFT;
          sh_nxt_s     = cap_s;
          div_nxt_s    = 5'd0;
          bit_nxt_s    = 6'd0;
          busy_nxt_s   = 1'b1;
          sframe_nxt_s = 1'b1;
          sdo_nxt_s    = cap_s[NB-1];
          sstb_nxt_s   = (DIV_LAST == 5'd0);
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      SHIFT: begin
        if (div_r == DIV_LAST) begin
          div_nxt_s = 5'd0;
          if (bit_r == BIT_LAST) begin
            state_nxt_s = DONE;
            sh_nxt_s    = '0;
            bit_nxt_s   = 6'd0;
            done_nxt_s  = 1'b1;
          end else begin
            // Bit period boundary: present the next bit at the start of its period.
            sh_nxt_s     = shifted_s;
            bit_nxt_s    = bit_r + 6'd1;
            busy_nxt_s   = 1'b1;
            sframe_nxt_s = 1'b1;
            sdo_nxt_s    = shifted_s[NB-1];
            sstb_nxt_s   = (DIV_LAST == 5'd0);
          end
        end else begin
          div_nxt_s    = div_r + 5'd1;
          busy_nxt_s   = 1'b1;
          sframe_nxt_s = 1'b1;
          sdo_nxt_s    = sh_r[NB-1];
          sstb_nxt_s   = ((div_r + 5'd1) == DIV_LAST);
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        sh_nxt_s    = '0;
        div_nxt_s   = 5'd0;
        bit_nxt_s   = 6'd0;
      end
    endcase
  end

  // State, counters, shift register and registered outputs; async reset discards any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      sh_r    <= '0;
      div_r   <= 5'd0;
      bit_r   <= 6'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sdo     <= 1'b0;
      sframe  <= 1'b0;
      sstb    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      sh_r    <= sh_nxt_s;
      div_r   <= div_nxt_s;
      bit_r   <= bit_nxt_s;
      busy    <= busy_nxt_s;
      done    <= done_nxt_s;
      sdo     <= sdo_nxt_s;
      sframe  <= sframe_nxt_s;
      sstb    <= sstb_nxt_s;
    end
  end

endmodule
